// File: rtl/uop_sequencer_pkg.sv
// Shared widths and encodings for the micro-op sequencer slice.
// Bundle entries are packed as {k, count, uop_2, uop_1, uop_0}.
package uop_sequencer_pkg;

  localparam int UOP_W_DEF = 20;
  localparam int K_W_DEF   = 16;
  localparam int CNT_W     = 2;

  localparam logic [UOP_W_DEF-1:0] NOP_UOP = '0;

  function automatic int entry_width(input int uop_w, input int k_w);
    return 3 * uop_w + k_w + CNT_W;
  endfunction

endpackage

// File: rtl/uop_bundle_fifo.sv
// Generic DEPTH-entry FIFO with occupancy and synchronous flush.
// The caller only pushes when not full and only pops when not empty.
module uop_bundle_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     a_rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is deliberately left unreset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uop_sequencer.sv
// Buffers decoded bundles from the front end and issues one uop per cycle
// to execute; a PC redirect (flush) discards all buffered work.
module uop_sequencer
  import uop_sequencer_pkg::*;
#(
  parameter int UOP_W = UOP_W_DEF,
  parameter int K_W   = K_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   a_rst,
  input  logic [UOP_W-1:0]       fe_uop_0,
  input  logic [UOP_W-1:0]       fe_uop_1,
  input  logic [UOP_W-1:0]       fe_uop_2,
  input  logic [CNT_W-1:0]       fe_uop_count,
  input  logic [K_W-1:0]         fe_k,
  input  logic                   fe_feed_ack,
  output logic                   fe_feed_req,
  input  logic                   flush,
  input  logic                   ex_ready,
  output logic                   ex_uop_valid,
  output logic [UOP_W-1:0]       ex_uop,
  output logic [K_W-1:0]         ex_k,
  output logic                   ex_last,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int E_W   = entry_width(UOP_W, K_W);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [E_W-1:0]   wr_data;
  logic [E_W-1:0]   rd_data;
  logic [UOP_W-1:0] head_uop_0;
  logic [UOP_W-1:0] head_uop_1;
  logic [UOP_W-1:0] head_uop_2;
  logic [CNT_W-1:0] head_count;
  logic [K_W-1:0]   head_k;
  logic [CNT_W-1:0] idx;
  logic             head_last;
  logic             push;
  logic             wr_en;
  logic             fire;
  logic             pop;

  assign wr_data = {fe_k, fe_uop_count, fe_uop_2, fe_uop_1, fe_uop_0};

  assign head_uop_0 = rd_data[UOP_W-1:0];
  assign head_uop_1 = rd_data[2*UOP_W-1:UOP_W];
  assign head_uop_2 = rd_data[3*UOP_W-1:2*UOP_W];
  assign head_count = rd_data[3*UOP_W+CNT_W-1:3*UOP_W];
  assign head_k     = rd_data[E_W-1:3*UOP_W+CNT_W];

  // Request comes from registered occupancy only: a pop this cycle does not reopen it.
  assign fe_feed_req  = (occupancy != OCC_W'(DEPTH));
  assign ex_uop_valid = (occupancy != '0);

  // Empty bundles are acknowledged but never stored.
  assign push  = fe_feed_req & fe_feed_ack & ~flush;
  assign wr_en = push & (fe_uop_count != '0);

  assign head_last = (idx == head_count - CNT_W'(1));
  assign fire      = ex_uop_valid & ex_ready & ~flush;
  assign pop       = fire & head_last;

  uop_bundle_fifo #(
    .W     (E_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .a_rst     (a_rst),
    .flush     (flush),
    .push      (wr_en),
    .pop       (pop),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      idx <= '0;
    end else if (flush) begin
      idx <= '0;
    end else if (fire) begin
      idx <= head_last ? '0 : idx + CNT_W'(1);
    end
  end

  always_comb begin
    ex_uop  = '0;
    ex_k    = '0;
    ex_last = 1'b0;
    if (ex_uop_valid) begin
      case (idx)
        2'd0:    ex_uop = head_uop_0;
        2'd1:    ex_uop = head_uop_1;
        default: ex_uop = head_uop_2;
      endcase
      ex_k    = head_k;
      ex_last = head_last;
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Scoreboard bench for uop_sequencer: expected uops are queued when a bundle
// is accepted and checked whenever execute consumes one.
module tb_uop_sequencer;

  localparam int UOP_W = 20;
  localparam int K_W   = 16;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             a_rst;
  logic [UOP_W-1:0] fe_uop_0, fe_uop_1, fe_uop_2;
  logic [1:0]       fe_uop_count;
  logic [K_W-1:0]   fe_k;
  logic             fe_feed_ack;
  logic             fe_feed_req;
  logic             flush;
  logic             ex_ready;
  logic             ex_uop_valid;
  logic [UOP_W-1:0] ex_uop;
  logic [K_W-1:0]   ex_k;
  logic             ex_last;
  logic [1:0]       occupancy;

  int total = 0;
  int bad   = 0;
  int fires = 0;
  logic [UOP_W+K_W:0] sb[$];

  uop_sequencer #(.UOP_W(UOP_W), .K_W(K_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .fe_uop_0     (fe_uop_0),
    .fe_uop_1     (fe_uop_1),
    .fe_uop_2     (fe_uop_2),
    .fe_uop_count (fe_uop_count),
    .fe_k         (fe_k),
    .fe_feed_ack  (fe_feed_ack),
    .fe_feed_req  (fe_feed_req),
    .flush        (flush),
    .ex_ready     (ex_ready),
    .ex_uop_valid (ex_uop_valid),
    .ex_uop       (ex_uop),
    .ex_k         (ex_k),
    .ex_last      (ex_last),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  // Every consumed uop must match the oldest expected one.
  always @(negedge clk) begin
    if (a_rst && ex_uop_valid && ex_ready && !flush) begin
      logic [UOP_W+K_W:0] exp_e;
      fires++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_issue: unexpected uop got=%h k=%h last=%b, none expected", ex_uop, ex_k, ex_last);
      end else begin
        exp_e = sb.pop_front();
        if ({ex_uop, ex_k, ex_last} !== exp_e) begin
          bad++;
          $display("FAIL sb_issue: got uop=%h k=%h last=%b want uop=%h k=%h last=%b",
                   ex_uop, ex_k, ex_last, exp_e[UOP_W+K_W:K_W+1], exp_e[K_W:1], exp_e[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [UOP_W-1:0] u0, input logic [UOP_W-1:0] u1,
                       input logic [UOP_W-1:0] u2, input logic [1:0] cnt,
                       input logic [K_W-1:0] k, input bit accept);
    fe_uop_0 = u0; fe_uop_1 = u1; fe_uop_2 = u2;
    fe_uop_count = cnt; fe_k = k; fe_feed_ack = 1'b1;
    if (accept) begin
      if (cnt > 0) sb.push_back({u0, k, cnt == 2'd1});
      if (cnt > 1) sb.push_back({u1, k, cnt == 2'd2});
      if (cnt > 2) sb.push_back({u2, k, 1'b1});
    end
  endtask

  task automatic test_reset();
    a_rst = 1'b0; flush = 1'b0; ex_ready = 1'b0; fe_feed_ack = 1'b0;
    fe_uop_0 = '0; fe_uop_1 = '0; fe_uop_2 = '0; fe_uop_count = '0; fe_k = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({fe_feed_req, ex_uop_valid, occupancy, ex_uop, ex_k, ex_last} !== {1'b1, 1'b0, 2'd0, 20'h0, 16'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_held: req=%b valid=%b occ=%0d uop=%h k=%h last=%b", fe_feed_req, ex_uop_valid, occupancy, ex_uop, ex_k, ex_last);
    end
    a_rst = 1'b1;
    step(); step();
    @(negedge clk);
    total++;
    if ({fe_feed_req, ex_uop_valid, occupancy} !== {1'b1, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL reset_released: req=%b valid=%b occ=%0d want 1 0 0", fe_feed_req, ex_uop_valid, occupancy);
    end
  endtask

  task automatic test_single();
    logic [UOP_W-1:0] exp_u [3];
    exp_u[0] = 20'h00001; exp_u[1] = 20'h00002; exp_u[2] = 20'h00003;
    ex_ready = 1'b1;
    step();
    drive(20'h00001, 20'h00002, 20'h00003, 2'd3, 16'hBEEF, 1'b1);
    @(negedge clk);
    total++;
    if (ex_uop_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_push_cycle: valid=%b want 0", ex_uop_valid);
    end
    step();
    fe_feed_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({ex_uop_valid, ex_uop, ex_k, ex_last} !== {1'b1, exp_u[i], 16'hBEEF, i == 2}) begin
        bad++;
        $display("FAIL single_uop%0d: valid=%b uop=%h k=%h last=%b want uop=%h k=beef last=%b",
                 i, ex_uop_valid, ex_uop, ex_k, ex_last, exp_u[i], i == 2);
      end
      step();
    end
    @(negedge clk);
    total++;
    if (ex_uop_valid !== 1'b0 || occupancy !== 2'd0) begin
      bad++;
      $display("FAIL single_drained: valid=%b occ=%0d want 0 0", ex_uop_valid, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    ex_ready = 1'b0;
    step();
    drive(20'h00010, 20'h00011, 20'h0, 2'd2, 16'h1111, 1'b1);
    step();
    drive(20'h00020, 20'h0, 20'h0, 2'd1, 16'h2222, 1'b1);
    step();
    drive(20'h00030, 20'h0, 20'h0, 2'd1, 16'h3333, 1'b0);
    @(negedge clk);
    total++;
    if ({occupancy, fe_feed_req, ex_uop} !== {2'd2, 1'b0, 20'h00010}) begin
      bad++;
      $display("FAIL bp_full: occ=%0d req=%b uop=%h want 2 0 00010", occupancy, fe_feed_req, ex_uop);
    end
    step();
    fe_feed_ack = 1'b0; ex_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({occupancy, fe_feed_req} !== {2'd2, 1'b0}) begin
      bad++;
      $display("FAIL bp_ack_ignored: occ=%0d req=%b want 2 0", occupancy, fe_feed_req);
    end
    step();
    @(negedge clk);
    total++;
    if ({fe_feed_req, ex_uop, ex_last} !== {1'b0, 20'h00011, 1'b1}) begin
      bad++;
      $display("FAIL bp_pop_cycle: req=%b uop=%h last=%b want 0 00011 1", fe_feed_req, ex_uop, ex_last);
    end
    step();
    @(negedge clk);
    total++;
    if ({fe_feed_req, occupancy, ex_uop} !== {1'b1, 2'd1, 20'h00020}) begin
      bad++;
      $display("FAIL bp_req_return: req=%b occ=%0d uop=%h want 1 1 00020", fe_feed_req, occupancy, ex_uop);
    end
    step();
    @(negedge clk);
    total++;
    if (ex_uop_valid !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL bp_drained: valid=%b pending=%0d want 0 0", ex_uop_valid, sb.size());
    end
  endtask

  task automatic test_count_zero();
    int f0;
    ex_ready = 1'b1;
    f0 = fires;
    step();
    drive(20'h00040, 20'h0, 20'h0, 2'd1, 16'h4444, 1'b1);
    step();
    drive(20'h00077, 20'h00078, 20'h00079, 2'd0, 16'h7777, 1'b1);
    step();
    drive(20'h00050, 20'h0, 20'h0, 2'd1, 16'h5555, 1'b1);
    @(negedge clk);
    total++;
    if (ex_uop_valid !== 1'b0 || occupancy !== 2'd0) begin
      bad++;
      $display("FAIL cnt0_dropped: valid=%b occ=%0d want 0 0", ex_uop_valid, occupancy);
    end
    step();
    fe_feed_ack = 1'b0;
    step(); step();
    @(negedge clk);
    total++;
    if (fires - f0 != 2) begin
      bad++;
      $display("FAIL cnt0_issue_count: issued=%0d want 2", fires - f0);
    end
  endtask

  task automatic test_flush();
    ex_ready = 1'b0;
    step();
    drive(20'h00060, 20'h00061, 20'h00062, 2'd3, 16'h6666, 1'b1);
    step();
    drive(20'h00070, 20'h0, 20'h0, 2'd1, 16'h7777, 1'b1);
    step();
    fe_feed_ack = 1'b0; ex_ready = 1'b1;
    step();
    ex_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({occupancy, ex_uop} !== {2'd2, 20'h00061}) begin
      bad++;
      $display("FAIL flush_setup: occ=%0d uop=%h want 2 00061", occupancy, ex_uop);
    end
    step();
    flush = 1'b1; ex_ready = 1'b1;
    drive(20'h00080, 20'h0, 20'h0, 2'd1, 16'h8888, 1'b0);
    step();
    flush = 1'b0; fe_feed_ack = 1'b0; ex_ready = 1'b0;
    sb.delete();
    @(negedge clk);
    total++;
    if ({occupancy, ex_uop_valid, ex_uop} !== {2'd0, 1'b0, 20'h0}) begin
      bad++;
      $display("FAIL flush_cleared: occ=%0d valid=%b uop=%h want 0 0 0", occupancy, ex_uop_valid, ex_uop);
    end
    step();
    ex_ready = 1'b1;
    drive(20'h00090, 20'h00091, 20'h0, 2'd2, 16'h9999, 1'b1);
    step();
    fe_feed_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({ex_uop, ex_k, ex_last} !== {20'h00090, 16'h9999, 1'b0}) begin
      bad++;
      $display("FAIL flush_restart_slot0: uop=%h k=%h last=%b want 00090 9999 0", ex_uop, ex_k, ex_last);
    end
    step(); step();
    flush = 1'b1;
    drive(20'h000E0, 20'h0, 20'h0, 2'd1, 16'hEEEE, 1'b0);
    step();
    flush = 1'b0; fe_feed_ack = 1'b0;
    @(negedge clk);
    total++;
    if (ex_uop_valid !== 1'b0 || occupancy !== 2'd0) begin
      bad++;
      $display("FAIL flush_blocks_push: valid=%b occ=%0d want 0 0", ex_uop_valid, occupancy);
    end
  endtask

  task automatic test_push_pop();
    ex_ready = 1'b0;
    step();
    drive(20'h000A0, 20'h000A1, 20'h0, 2'd2, 16'hAAAA, 1'b1);
    step();
    fe_feed_ack = 1'b0; ex_ready = 1'b1;
    step();
    drive(20'h000B0, 20'h0, 20'h0, 2'd1, 16'hBBBB, 1'b1);
    @(negedge clk);
    total++;
    if ({occupancy, ex_uop, ex_last, fe_feed_req} !== {2'd1, 20'h000A1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL pp_before: occ=%0d uop=%h last=%b req=%b want 1 000a1 1 1", occupancy, ex_uop, ex_last, fe_feed_req);
    end
    step();
    fe_feed_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({occupancy, ex_uop, ex_k, ex_last} !== {2'd1, 20'h000B0, 16'hBBBB, 1'b1}) begin
      bad++;
      $display("FAIL pp_after: occ=%0d uop=%h k=%h last=%b want 1 000b0 bbbb 1", occupancy, ex_uop, ex_k, ex_last);
    end
    step();
  endtask

  task automatic test_async_reset();
    ex_ready = 1'b0;
    step();
    drive(20'h000C0, 20'h000C1, 20'h000C2, 2'd3, 16'hCCCC, 1'b1);
    step();
    fe_feed_ack = 1'b0; ex_ready = 1'b1;
    step();
    ex_ready = 1'b0;
    #2 a_rst = 1'b0;
    #1;
    total++;
    if ({occupancy, ex_uop_valid, fe_feed_req, ex_uop} !== {2'd0, 1'b0, 1'b1, 20'h0}) begin
      bad++;
      $display("FAIL async_reset: occ=%0d valid=%b req=%b uop=%h want 0 0 1 0", occupancy, ex_uop_valid, fe_feed_req, ex_uop);
    end
    sb.delete();
    step();
    a_rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_count_zero();
    test_flush();
    test_push_pop();
    test_async_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: pending=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
